uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
Frame controller between the UART receiver, the ALU and the UART transmitter. Collects a 3-byte command frame from the receiver in a fixed order: operand1, operand2, opcode. It then presents the latched operands and opcode to the combinational ALU, captures the result, and streams it to the transmitter byte by byte, MSB first. Also handles inter-byte timeout and transmitter back-pressure.

Parameters:
NB_DATA, 8, operand width and UART byte width
NB_OP, 6, opcode width; taken from the low NB_OP bits of the opcode byte
NB_OUT, 16, ALU result width; must be a multiple of NB_DATA
TIMEOUT_CYCLES, 500000, maximum idle clocks between frame bytes before the frame is aborted

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  NB_DATA  received byte; valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse from the receiver
i_alu_result  in  NB_OUT  combinational ALU result
i_tx_busy  in  1  transmitter is serializing
i_tx_done  in  1  one-cycle pulse, transmitter byte finished
o_operand1  out  NB_DATA  latched operand1 to ALU
o_operand2  out  NB_DATA  latched operand2 to ALU
o_opcode  out  NB_OP  latched opcode to ALU
o_tx_data  out  NB_DATA  byte to transmit
o_tx_start  out  1  one-cycle transmit request
o_result_valid  out  1  one-cycle pulse when the result is captured
o_frame_err  out  1  one-cycle pulse on timeout abort
o_rx_drop  out  1  one-cycle pulse when a byte is ignored
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; all outputs 0; internal result register, byte counter and timeout counter = 0.
- States: IDLE, GET_OP2, GET_OPCODE, EXEC, TX_LOAD, TX_WAIT.
- IDLE: on i_rx_done, latch o_operand1<=i_rx_data, go to GET_OP2.
- GET_OP2: on i_rx_done, latch o_operand2, go to GET_OPCODE.
- GET_OPCODE: on i_rx_done, latch o_opcode<=i_rx_data[NB_OP-1:0] (upper bits ignored), go to EXEC.
- Timeout (GET_OP2 and GET_OPCODE only):
  - The counter clears on entry and on every accepted byte, and increments each clock otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done: pulse o_frame_err, go to IDLE.
  - Latched operands are kept as-is.
  - If i_rx_done coincides with expiry, the byte is accepted and there is no error.
- EXEC: one cycle after the opcode latch, so ALU inputs have settled.
  - Register i_alu_result, pulse o_result_valid, clear byte index, go to TX_LOAD.
- TX_LOAD:
  - o_tx_data = result byte at index k, where k=0 is bits [NB_OUT-1:NB_OUT-NB_DATA].
  - If i_tx_busy=0: pulse o_tx_start for exactly one cycle, go to TX_WAIT.
  - Otherwise hold in TX_LOAD with no start pulse.
- TX_WAIT: o_tx_data held stable. On i_tx_done:
  - if k < NB_OUT/NB_DATA-1: k++, go to TX_LOAD;
  - otherwise go to IDLE.
- Dropped bytes: i_rx_done in EXEC, TX_LOAD or TX_WAIT is ignored with an o_rx_drop pulse; the state is unchanged.
- Latency:
  - Opcode-byte i_rx_done to o_result_valid: 2 clocks.
  - Opcode-byte i_rx_done to first o_tx_start: 3 clocks when the transmitter is idle.
- o_operand1/2 and o_opcode change only on their own latch events, so the ALU sees stable inputs throughout transmission.
- Reset asserted mid-frame or mid-transmission: immediate return to IDLE, outputs cleared; an in-flight transmitter byte is not tracked.

Optional Feature:
Macro: SEQ_CHECKSUM_EN.
- Defined: after the last result byte, one extra byte is sent through the same TX_LOAD/TX_WAIT handshake.
  - Checksum = XOR of operand1, operand2, {pad zeros, opcode} and all result bytes.
  - The frame is NB_OUT/NB_DATA+1 bytes.
- Undefined: no checksum logic; the frame is exactly NB_OUT/NB_DATA bytes.

Test Plan:
- Nominal frame: rx bytes 0x05, 0x03, 0x20, stub i_alu_result=0x0008, tx idle -> o_operand1=0x05, o_operand2=0x03, o_opcode=0x20; o_result_valid 2 clocks after the third rx_done; tx bytes 0x00 then 0x08; o_busy low after the second i_tx_done.
- Back-pressure: i_tx_busy=1 for 20 clocks when entering TX_LOAD -> no o_tx_start during those 20 clocks; a single start pulse on the first cycle busy=0; o_tx_data stable throughout.
- Timeout: TIMEOUT_CYCLES=10, send 0x11, then silence -> o_frame_err pulse 10 clocks after GET_OP2 entry; state IDLE; the next byte 0x22 is latched as operand1.
- Boundary: third rx_done on the exact expiry cycle -> accepted, no o_frame_err, transmission proceeds.
- Drop: rx_done with 0xAA during TX_WAIT -> o_rx_drop pulse; operands and transmitted bytes unchanged.
- Async reset asserted during TX_WAIT of byte 0 -> all outputs 0 immediately; a new frame 0x01, 0x01, 0x20 completes normally. With SEQ_CHECKSUM_EN, nominal frame with stub result 0x0008 -> third tx byte = 0x05^0x03^0x20^0x00^0x08 = 0x2E.

Source files
------------

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - UART command-frame sequencer: rx operands/opcode, ALU capture, MSB-first tx
// Optional SEQ_CHECKSUM_EN appends an XOR checksum byte after the result bytes.
module uart_alu_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_OUT         = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_OUT-1:0]  i_alu_result,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_operand1,
  output logic [NB_DATA-1:0] o_operand2,
  output logic [NB_OP-1:0]   o_opcode,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_result_valid,
  output logic               o_frame_err,
  output logic               o_rx_drop,
  output logic               o_busy
);
  localparam int NB_RES_BYTES = NB_OUT / NB_DATA;
`ifdef SEQ_CHECKSUM_EN
  localparam int NB_TX_BYTES = NB_RES_BYTES + 1;
`else
  localparam int NB_TX_BYTES = NB_RES_BYTES;
`endif
  localparam int KW = $clog2(NB_TX_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NB_TX_BYTES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GET_OP2, GET_OPCODE, EXEC, TX_LOAD, TX_WAIT} state_t;

  state_t             state, state_next;
  logic [NB_OUT-1:0]  result;
  logic [KW-1:0]      byte_idx, byte_idx_next;
  logic [TW-1:0]      tmo_cnt, tmo_cnt_next;
  logic [NB_DATA-1:0] operand1_next, operand2_next;
  logic [NB_OP-1:0]   opcode_next;
  logic               tx_start_next, result_valid_next, frame_err_next, rx_drop_next;
  logic               capture;
  logic [NB_DATA-1:0] tx_byte;

  always_comb begin
    state_next        = state;
    operand1_next     = o_operand1;
    operand2_next     = o_operand2;
    opcode_next       = o_opcode;
    byte_idx_next     = byte_idx;
    tmo_cnt_next      = tmo_cnt;
    tx_start_next     = 1'b0;
    result_valid_next = 1'b0;
    frame_err_next    = 1'b0;
    rx_drop_next      = 1'b0;
    capture           = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_done) begin
          operand1_next = i_rx_data;
          tmo_cnt_next  = '0;
          state_next    = GET_OP2;
        end
      end
      GET_OP2: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (i_rx_done) begin
          operand2_next = i_rx_data;
          tmo_cnt_next  = '0;
          state_next    = GET_OPCODE;
        end else if (tmo_cnt == T_LAST) begin
          frame_err_next = 1'b1;
          tmo_cnt_next   = '0;
          state_next     = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end
      GET_OPCODE: begin
        if (i_rx_done) begin
          opcode_next  = i_rx_data[NB_OP-1:0];
          tmo_cnt_next = '0;
          state_next   = EXEC;
        end else if (tmo_cnt == T_LAST) begin
          frame_err_next = 1'b1;
          tmo_cnt_next   = '0;
          state_next     = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end
      EXEC: begin
        capture           = 1'b1;
        result_valid_next = 1'b1;
        byte_idx_next     = '0;
        state_next        = TX_LOAD;
      end
      TX_LOAD: begin
        if (!i_tx_busy) begin
          tx_start_next = 1'b1;
          state_next    = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (i_tx_done) begin
          if (byte_idx < K_LAST) begin
            byte_idx_next = byte_idx + 1'b1;
            state_next    = TX_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (i_rx_done && (state == EXEC || state == TX_LOAD || state == TX_WAIT)) begin
      rx_drop_next = 1'b1;
    end
  end

`ifdef SEQ_CHECKSUM_EN
  logic [NB_DATA-1:0] checksum;

  always_comb begin
    checksum = o_operand1 ^ o_operand2 ^ NB_DATA'(o_opcode);
    for (int i = 0; i < NB_RES_BYTES; i++) begin
      checksum = checksum ^ result[NB_OUT-1-i*NB_DATA -: NB_DATA];
    end
  end
`endif

  // Byte 0 is the most significant slice of the captured result.
  always_comb begin
    tx_byte = '0;
    for (int i = 0; i < NB_RES_BYTES; i++) begin
      if (byte_idx == KW'(i)) tx_byte = result[NB_OUT-1-i*NB_DATA -: NB_DATA];
    end
`ifdef SEQ_CHECKSUM_EN
    if (byte_idx == KW'(NB_RES_BYTES)) tx_byte = checksum;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      result         <= '0;
      byte_idx       <= '0;
      tmo_cnt        <= '0;
      o_operand1     <= '0;
      o_operand2     <= '0;
      o_opcode       <= '0;
      o_tx_start     <= 1'b0;
      o_result_valid <= 1'b0;
      o_frame_err    <= 1'b0;
      o_rx_drop      <= 1'b0;
    end else begin
      state          <= state_next;
      byte_idx       <= byte_idx_next;
      tmo_cnt        <= tmo_cnt_next;
      o_operand1     <= operand1_next;
      o_operand2     <= operand2_next;
      o_opcode       <= opcode_next;
      o_tx_start     <= tx_start_next;
      o_result_valid <= result_valid_next;
      o_frame_err    <= frame_err_next;
      o_rx_drop      <= rx_drop_next;
      if (capture) result <= i_alu_result;
    end
  end

  assign o_tx_data = tx_byte;
  assign o_busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - scoreboard bench for uart_alu_sequencer
`timescale 1ns/1ps
module tb_uart_alu_sequencer;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int NB_OUT  = 16;
  localparam int TO      = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        model_busy = 1'b0;
  logic        hold_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_busy;
  logic [7:0]  operand1, operand2, tx_data;
  logic [5:0]  opcode;
  logic        tx_start, result_valid, frame_err, rx_drop, busy;

  assign tx_busy = model_busy | hold_busy;

  uart_alu_sequencer #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_OUT(NB_OUT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_alu_result(alu_result), .i_tx_busy(tx_busy), .i_tx_done(tx_done),
    .o_operand1(operand1), .o_operand2(operand2), .o_opcode(opcode),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_result_valid(result_valid),
    .o_frame_err(frame_err), .o_rx_drop(rx_drop), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  logic [7:0]  exp_tx[$];
  logic [21:0] exp_rv[$];
  int exp_err = 0, exp_drop = 0;
  int rv_cyc = -1, err_cyc = -1, first_start_cyc = -1;
  int start_cnt = 0, err_seen = 0, drop_seen = 0, last_rx_cyc = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        start_cnt++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        check("start_while_busy", 32'(prev_busy), 32'd0);
        check("tx_start_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (result_valid) begin
        rv_cyc = cyc;
        check("result_valid_expected", 32'(exp_rv.size() != 0), 32'd1);
        if (exp_rv.size() != 0) check("latched_inputs", 32'({operand1, operand2, opcode}), 32'(exp_rv.pop_front()));
      end
      if (frame_err) begin
        err_cyc = cyc;
        err_seen++;
        check("frame_err_expected", 32'(exp_err != 0), 32'd1);
        if (exp_err > 0) exp_err--;
      end
      if (rx_drop) begin
        drop_seen++;
        check("rx_drop_expected", 32'(exp_drop != 0), 32'd1);
        if (exp_drop > 0) exp_drop--;
      end
    end
    prev_busy = tx_busy;
  end

  // Transmitter model: busy for four cycles after each start, then a done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        #1 model_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1 tx_done = 1'b1;
        model_busy = 1'b0;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic expect_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [15:0] r);
    exp_rv.push_back({a, b, c[5:0]});
    exp_tx.push_back(r[15:8]);
    exp_tx.push_back(r[7:0]);
`ifdef SEQ_CHECKSUM_EN
    exp_tx.push_back(a ^ b ^ {2'b00, c[5:0]} ^ r[15:8] ^ r[7:0]);
`endif
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_start(input string name, input int budget);
    int s0 = start_cnt;
    int n = 0;
    while (start_cnt == s0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(start_cnt != s0), 32'd1);
  endtask

  initial begin
    int rx3, rx1, rx2, s0, stable_bad, free_cyc, e0, d0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", 32'(|{operand1, operand2, opcode, tx_data, tx_start,
                                     result_valid, frame_err, rx_drop, busy}), 32'd0);
    rst_n = 1'b1;

    // Nominal frame
    alu_result = 16'h0008;
    expect_frame(8'h05, 8'h03, 8'h20, 16'h0008);
    first_start_cyc = -1;
    send_frame(8'h05, 8'h03, 8'h20);
    rx3 = last_rx_cyc;
    wait_idle("nominal_idle", 80);
    check("nominal_op1", 32'(operand1), 32'h05);
    check("nominal_op2", 32'(operand2), 32'h03);
    check("nominal_opcode", 32'(opcode), 32'h20);
    check("nominal_rv_latency", 32'(rv_cyc - rx3), 32'd2);
    check("nominal_start_latency", 32'(first_start_cyc - rx3), 32'd3);
    check("nominal_tx_drained", 32'(exp_tx.size()), 32'd0);

    // Back-pressure
    alu_result = 16'h1234;
    expect_frame(8'h0C, 8'h0D, 8'h01, 16'h1234);
    @(posedge clk);
    #1 hold_busy = 1'b1;
    s0 = start_cnt;
    send_frame(8'h0C, 8'h0D, 8'h01);
    @(posedge clk);
    stable_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_data !== 8'h12) stable_bad++;
    end
    check("bp_no_start", 32'(start_cnt - s0), 32'd0);
    check("bp_data_stable", 32'(stable_bad), 32'd0);
    first_start_cyc = -1;
    @(posedge clk);
    #1 hold_busy = 1'b0;
    free_cyc = cyc;
    wait_idle("bp_idle", 80);
    check("bp_start_after_release", 32'(first_start_cyc - free_cyc), 32'd1);
    check("bp_start_count", 32'(start_cnt - s0), 32'(exp_rv.size() == 0 ? NB_OUT / NB_DATA
`ifdef SEQ_CHECKSUM_EN
                                                    + 1
`endif
                                                    : 0));

    // Timeout after operand1
    exp_err = 1;
    err_cyc = -1;
    send_byte(8'h11);
    rx1 = last_rx_cyc;
    repeat (14) @(negedge clk);
    check("timeout_err_cycle", 32'(err_cyc - rx1), 32'd11);
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_op1_kept", 32'(operand1), 32'h11);
    check("timeout_err_consumed", 32'(exp_err), 32'd0);
    alu_result = 16'hBEEF;
    expect_frame(8'h22, 8'h04, 8'h01, 16'hBEEF);
    send_frame(8'h22, 8'h04, 8'h01);
    wait_idle("post_timeout_idle", 80);
    check("post_timeout_op1", 32'(operand1), 32'h22);

    // Opcode byte on the exact expiry cycle
    alu_result = 16'h0102;
    expect_frame(8'h07, 8'h09, 8'hEA, 16'h0102);
    e0 = err_seen;
    send_byte(8'h07);
    send_byte(8'h09);
    rx2 = last_rx_cyc;
    repeat (8) @(posedge clk);
    send_byte(8'hEA);
    check("boundary_rx_cycle", 32'(last_rx_cyc - rx2), 32'd10);
    wait_idle("boundary_idle", 80);
    check("boundary_no_err", 32'(err_seen - e0), 32'd0);
    check("boundary_opcode", 32'(opcode), 32'h2A);

    // Byte dropped during TX_WAIT
    alu_result = 16'h5A5A;
    expect_frame(8'h10, 8'h20, 8'h30, 16'h5A5A);
    d0 = drop_seen;
    exp_drop = 1;
    send_frame(8'h10, 8'h20, 8'h30);
    wait_start("drop_first_start", 30);
    send_byte(8'hAA);
    wait_idle("drop_idle", 80);
    check("drop_pulses", 32'(drop_seen - d0), 32'd1);
    check("drop_ops", 32'({operand1, operand2, opcode}), 32'({8'h10, 8'h20, 6'h30}));

    // Asynchronous reset during TX_WAIT of byte 0
    alu_result = 16'h00FF;
    exp_rv.push_back({8'h33, 8'h44, 6'h05});
    exp_tx.push_back(8'h00);
    send_frame(8'h33, 8'h44, 8'h05);
    wait_start("rst_first_start", 30);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(|{operand1, operand2, opcode, tx_data, tx_start,
                                          result_valid, frame_err, rx_drop, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    alu_result = 16'h0040;
    expect_frame(8'h01, 8'h01, 8'h20, 16'h0040);
    send_frame(8'h01, 8'h01, 8'h20);
    wait_idle("post_reset_idle", 80);
    check("post_reset_ops", 32'({operand1, operand2, opcode}), 32'({8'h01, 8'h01, 6'h20}));

    check("final_tx_queue", 32'(exp_tx.size()), 32'd0);
    check("final_rv_queue", 32'(exp_rv.size()), 32'd0);
    check("final_err_pending", 32'(exp_err), 32'd0);
    check("final_drop_pending", 32'(exp_drop), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
